mbist_march_ctrl: RTL and testbench

Sequencer for the MBIST background-pattern decoder. It drives the 3-bit pattern select `q` and reads back the decoded 8-bit `data_t`. For each of the six defined patterns (q = 0..5), it writes the background to every address of the memory under test, then reads every address back and compares. It sits between the top-level BIST start/status interface and the memory port, and records the first failing address and pattern plus a saturating mismatch count.

---
 rtl/mbist_march_if.sv | 55 +++++
 rtl/mbist_march_ctrl.sv | 150 +++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_if.sv
// Bundle between the MBIST march sequencer and its environment:
// start/status, pattern-decoder select/readback and the memory port.
interface mbist_march_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [2:0]        q;
  logic [DATA_W-1:0] data_t;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_q;
  logic [7:0]        err_cnt;

  modport master (
    input  start,
    input  data_t,
    input  mem_rdata,
    output q,
    output mem_addr,
    output mem_we,
    output mem_re,
    output mem_wdata,
    output busy,
    output done,
    output fail,
    output fail_addr,
    output fail_q,
    output err_cnt
  );

  modport slave (
    output start,
    output data_t,
    output mem_rdata,
    input  q,
    input  mem_addr,
    input  mem_we,
    input  mem_re,
    input  mem_wdata,
    input  busy,
    input  done,
    input  fail,
    input  fail_addr,
    input  fail_q,
    input  err_cnt
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// MBIST march sequencer: per background pattern, write all addresses,
// read them back and log first failing address/pattern and error count.
module mbist_march_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int NPAT   = 6
) (
  input  logic          clk,
  input  logic          rst,
  mbist_march_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ALAST = '1;
  localparam logic [2:0]        QLAST = 3'(NPAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        pat_q, pat_d;
  logic              cvld_q, cvld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic              done_q, done_d;
  logic              flag_q, flag_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [2:0]        fpat_q, fpat_d;
  logic [7:0]        err_q, err_d;
  logic              mism;

  // Read data lands one cycle after the strobe; compare it then.
  assign mism = cvld_q && (bus.mem_rdata !== exp_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pat_d   = pat_q;
    cvld_d  = 1'b0;
    exp_d   = exp_q;
    caddr_d = caddr_q;
    done_d  = done_q;
    flag_d  = flag_q;
    faddr_d = faddr_q;
    fpat_d  = fpat_q;
    err_d   = err_q;

    if (mism) begin
      if (!flag_q) begin
        flag_d  = 1'b1;
        faddr_d = caddr_q;
        fpat_d  = pat_q;
      end
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WR;
          addr_d  = '0;
          pat_d   = '0;
          done_d  = 1'b0;
          flag_d  = 1'b0;
          faddr_d = '0;
          fpat_d  = '0;
          err_d   = '0;
        end
      end
      S_WR: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ALAST) begin
          state_d = S_RD;
          addr_d  = '0;
        end
      end
      S_RD: begin
        cvld_d  = 1'b1;
        exp_d   = bus.data_t;
        caddr_d = addr_q;
        addr_d  = addr_q + ADDR_W'(1);
        if (addr_q == ALAST) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end
      end
      S_DRAIN: begin
        addr_d = '0;
        if (pat_q < QLAST) begin
          pat_d   = pat_q + 3'd1;
          state_d = S_WR;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pat_q   <= '0;
      cvld_q  <= 1'b0;
      exp_q   <= '0;
      caddr_q <= '0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      faddr_q <= '0;
      fpat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      cvld_q  <= cvld_d;
      exp_q   <= exp_d;
      caddr_q <= caddr_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
      faddr_q <= faddr_d;
      fpat_q  <= fpat_d;
      err_q   <= err_d;
    end
  end

  assign bus.q         = pat_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = (state_q == S_WR);
  assign bus.mem_re    = (state_q == S_RD);
  assign bus.mem_wdata = bus.mem_we ? bus.data_t : '0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.fail      = flag_q;
  assign bus.fail_addr = faddr_q;
  assign bus.fail_q    = fpat_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: decoder and faulty-memory models plus a
// sweep-level reference of expected mismatches per run.
module tb_mbist_march_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start_r;
  bit   sel;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mbist_march_if #(.ADDR_W(4), .DATA_W(8)) ia ();
  mbist_march_if #(.ADDR_W(6), .DATA_W(8)) ib ();

  mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .NPAT(6)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.master)
  );
  mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .NPAT(6)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.master)
  );

  function automatic logic [7:0] dec(input logic [2:0] p);
    case (p)
      3'd0: return 8'hAA;
      3'd1: return 8'h55;
      3'd2: return 8'hF0;
      3'd3: return 8'h0F;
      3'd4: return 8'h00;
      3'd5: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // fault modes: 0 ideal, 3 ignore writes / read 0xFF, other: masked cell
  int         fmode = 0;
  int         fa = 0;
  int         fq = -1;
  logic [7:0] and_m = 8'hFF;
  logic [7:0] or_m = 8'h00;

  function automatic logic [7:0] fval(input int a, input int p,
                                      input logic [7:0] v);
    if (fmode == 3) return 8'hFF;
    if (fmode != 0 && a == fa && (fq < 0 || p == fq))
      return (v & and_m) | or_m;
    return v;
  endfunction

  assign ia.data_t = dec(ia.q);
  assign ib.data_t = dec(ib.q);
  assign ia.start  = start_r & ~sel;
  assign ib.start  = start_r & sel;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [64];

  always @(posedge clk) begin
    if (ia.mem_we) mem_a[ia.mem_addr] <= ia.mem_wdata;
    if (ia.mem_re)
      ia.mem_rdata <= fval(int'(ia.mem_addr), int'(ia.q), mem_a[ia.mem_addr]);
    if (ib.mem_we) mem_b[ib.mem_addr] <= ib.mem_wdata;
    if (ib.mem_re)
      ib.mem_rdata <= fval(int'(ib.mem_addr), int'(ib.q), mem_b[ib.mem_addr]);
  end

  logic       s_busy, s_done, s_fail, s_we, s_re;
  logic [2:0] s_q, s_fq;
  logic [5:0] s_faddr, s_addr;
  logic [7:0] s_wdata, s_err;

  assign s_busy  = sel ? ib.busy : ia.busy;
  assign s_done  = sel ? ib.done : ia.done;
  assign s_fail  = sel ? ib.fail : ia.fail;
  assign s_we    = sel ? ib.mem_we : ia.mem_we;
  assign s_re    = sel ? ib.mem_re : ia.mem_re;
  assign s_q     = sel ? ib.q : ia.q;
  assign s_fq    = sel ? ib.fail_q : ia.fail_q;
  assign s_faddr = sel ? ib.fail_addr : {2'b00, ia.fail_addr};
  assign s_addr  = sel ? ib.mem_addr : {2'b00, ia.mem_addr};
  assign s_wdata = sel ? ib.mem_wdata : ia.mem_wdata;
  assign s_err   = sel ? ib.err_cnt : ia.err_cnt;

  logic       pre_fail;
  logic [7:0] pre_err;

  task automatic sweep(input int aw, output int ecnt, output int eaddr,
                       output int eq, output bit efl);
    logic [7:0] w, r;
    ecnt = 0; eaddr = 0; eq = 0; efl = 0;
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < (1 << aw); a++) begin
        w = dec(3'(p));
        r = fval(a, p, w);
        if (r !== w) begin
          if (!efl) begin
            efl = 1; eaddr = a; eq = p;
          end
          ecnt++;
        end
      end
    end
    if (ecnt > 255) ecnt = 255;
  endtask

  task automatic run_check(input bit s, input int aw, input string nm);
    int d = 1 << aw;
    int per = 2 * d + 1;
    int exp_c = 6 * per + 1;
    int c, p, ecnt, eaddr, eq;
    bit efl;
    sweep(aw, ecnt, eaddr, eq, efl);
    sel = s;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    c = 1;
    checks++;
    if (s_fail !== 1'b0 || s_err !== 8'd0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL %s clear: fail=%0b err=%0d done=%0b want 0 0 0",
               nm, s_fail, s_err, s_done);
    end
    pre_fail = 1'b0;
    pre_err = 8'd0;
    while (!s_done && c < exp_c + 20) begin
      p = (c - 1) / per;
      checks++;
      if (s_busy !== 1'b1 || s_q !== 3'(p)) begin
        errors++;
        $display("FAIL %s busy_q c=%0d: busy=%0b q=%0d want 1 %0d",
                 nm, c, s_busy, s_q, p);
      end
      checks++;
      if (s_wdata !== (s_we ? dec(3'(p)) : 8'h00)) begin
        errors++;
        $display("FAIL %s wdata c=%0d: got %h want %h",
                 nm, c, s_wdata, s_we ? dec(3'(p)) : 8'h00);
      end
      pre_fail = s_fail;
      pre_err = s_err;
      @(posedge clk);
      #1;
      c++;
    end
    checks++;
    if (c !== exp_c) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", nm, c, exp_c);
    end
    checks++;
    if (s_busy !== 1'b0 || s_we !== 1'b0 || s_re !== 1'b0 || s_addr !== 6'd0) begin
      errors++;
      $display("FAIL %s idle_out: busy=%0b we=%0b re=%0b addr=%0d want 0",
               nm, s_busy, s_we, s_re, s_addr);
    end
    checks++;
    if (s_fail !== efl || s_err !== 8'(ecnt)) begin
      errors++;
      $display("FAIL %s status: fail=%0b err=%0d want %0b %0d",
               nm, s_fail, s_err, efl, ecnt);
    end
    checks++;
    if (s_faddr !== 6'(eaddr) || s_fq !== 3'(eq)) begin
      errors++;
      $display("FAIL %s first: addr=%0d q=%0d want %0d %0d",
               nm, s_faddr, s_fq, eaddr, eq);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_r = 1'b0;
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ia.q, ia.mem_addr, ia.mem_we, ia.mem_re, ia.mem_wdata, ia.busy,
         ia.done, ia.fail, ia.fail_addr, ia.fail_q, ia.err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: q=%0d addr=%0d busy=%0b done=%0b err=%0d want 0",
               ia.q, ia.mem_addr, ia.busy, ia.done, ia.err_cnt);
    end
    checks++;
    if ({ib.q, ib.mem_addr, ib.mem_we, ib.mem_re, ib.mem_wdata, ib.busy,
         ib.done, ib.fail, ib.fail_addr, ib.fail_q, ib.err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_b: q=%0d addr=%0d busy=%0b done=%0b err=%0d want 0",
               ib.q, ib.mem_addr, ib.busy, ib.done, ib.err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ideal;
    fmode = 0;
    run_check(1'b0, 4, "ideal");
    checks++;
    if (ia.q !== 3'd5) begin
      errors++;
      $display("FAIL ideal q_hold: got %0d want 5", ia.q);
    end
  endtask

  task automatic test_stuck_bit0;
    fmode = 1; fa = 5; fq = -1; and_m = 8'hFE; or_m = 8'h00;
    run_check(1'b0, 4, "sa0_bit0");
    checks++;
    if (ia.fail !== 1'b1 || ia.fail_addr !== 4'd5 || ia.fail_q !== 3'd1 ||
        ia.err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL sa0_bit0 fixed: fail=%0b addr=%0d q=%0d err=%0d want 1 5 1 3",
               ia.fail, ia.fail_addr, ia.fail_q, ia.err_cnt);
    end
  endtask

  task automatic test_drain_mismatch;
    fmode = 2; fa = 15; fq = 5; and_m = 8'h00; or_m = 8'h00;
    run_check(1'b0, 4, "drain");
    checks++;
    if (ia.err_cnt !== 8'd1 || ia.fail_addr !== 4'd15 || ia.fail_q !== 3'd5) begin
      errors++;
      $display("FAIL drain fixed: err=%0d addr=%0d q=%0d want 1 15 5",
               ia.err_cnt, ia.fail_addr, ia.fail_q);
    end
    checks++;
    if (pre_fail !== 1'b0 || pre_err !== 8'd0) begin
      errors++;
      $display("FAIL drain pre_done: fail=%0b err=%0d want 0 0",
               pre_fail, pre_err);
    end
  endtask

  task automatic test_saturate;
    fmode = 3;
    run_check(1'b1, 6, "saturate");
    checks++;
    if (ib.err_cnt !== 8'd255 || ib.fail_addr !== 6'd0 || ib.fail_q !== 3'd0) begin
      errors++;
      $display("FAIL saturate fixed: err=%0d addr=%0d q=%0d want 255 0 0",
               ib.err_cnt, ib.fail_addr, ib.fail_q);
    end
    sel = 1'b0;
  endtask

  task automatic test_restart_reset;
    int c;
    fmode = 0;
    sel = 1'b0;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    c = 1;
    while (c < 100) begin
      start_r = (c == 50);
      checks++;
      if (ia.busy !== 1'b1 || ia.q !== 3'((c - 1) / 33)) begin
        errors++;
        $display("FAIL restart c=%0d: busy=%0b q=%0d want 1 %0d",
                 c, ia.busy, ia.q, (c - 1) / 33);
      end
      @(posedge clk);
      #1;
      c++;
    end
    start_r = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({ia.q, ia.mem_addr, ia.mem_we, ia.mem_re, ia.mem_wdata, ia.busy,
         ia.done, ia.fail, ia.fail_addr, ia.fail_q, ia.err_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst: q=%0d addr=%0d busy=%0b done=%0b want 0",
               ia.q, ia.mem_addr, ia.busy, ia.done);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ia.done !== 1'b0 || ia.busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle: done=%0b busy=%0b want 0 0",
                 ia.done, ia.busy);
      end
    end
    run_check(1'b0, 4, "after_rst");
  endtask

  task automatic test_random;
    for (int it = 0; it < 5; it++) begin
      fmode = 4;
      fa = $urandom_range(0, 15);
      fq = int'($urandom_range(0, 6)) - 1;
      and_m = 8'($urandom);
      or_m = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_check(1'b0, 4, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;
    test_reset();
    test_ideal();
    test_stuck_bit0();
    test_drain_mismatch();
    test_saturate();
    test_restart_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
